// File: rtl/elelock_ctrl_if.sv
// Keypad / key-datapath signal bundle for the electronic-lock sequencing controller.
// master = keypad and datapath side, slave = the controller.
interface elelock_ctrl_if;
    logic [9:0] tenkey;
    logic       close;
    logic       enter;
    logic       match;
    logic       key_shift;
    logic [3:0] key_code;
    logic       key_clear;
    logic       secret_load;
    logic       lock;
    logic       alarm;
    logic [2:0] fail_cnt;
    logic [2:0] digits;

    modport master (
        output tenkey, close, enter, match,
        input  key_shift, key_code, key_clear, secret_load, lock, alarm, fail_cnt, digits
    );

    modport slave (
        input  tenkey, close, enter, match,
        output key_shift, key_code, key_clear, secret_load, lock, alarm, fail_cnt, digits
    );
endinterface

// File: rtl/elelock_ctrl.sv
// Electronic-lock sequencer: tenkey edge detect/encode, digit count, lock FSM,
// failed-attempt counting with timed lockout and alarm.
module elelock_ctrl #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCKOUT_CYC = 1000
) (
    input  logic          ck,
    input  logic          reset_n,
    elelock_ctrl_if.slave bus
);
    localparam int unsigned TIMER_W = 16;
    localparam int unsigned CNT_W   = 3;

    typedef enum logic [1:0] {
        ST_OPEN    = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_ke1;
    logic               r_ke2;
    logic               r_kv;
    logic [3:0]         r_key_code;
    logic               r_lock;
    logic               r_alarm;
    logic [CNT_W-1:0]   r_fail_cnt;
    logic [CNT_W-1:0]   r_digits;
    logic [TIMER_W-1:0] r_timer;

    logic w_onehot;
    logic w_full;
    logic w_close_act;
    logic w_enter_act;
    logic w_key_shift;
    logic w_key_clear;
    logic w_secret_load;
    logic w_fail_limit;

    function automatic logic is_onehot(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

    function automatic logic [3:0] enc(input logic [9:0] v);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) code = 4'(i);
        end
        return code;
    endfunction

    assign w_onehot     = is_onehot(bus.tenkey);
    assign w_full       = (r_digits == CNT_W'(DIGITS));
    assign w_close_act  = (r_state == ST_OPEN) && bus.close && w_full;
    assign w_enter_act  = (r_state == ST_LOCKED) && bus.enter;
    assign w_fail_limit = ((4'(r_fail_cnt) + 4'd1) >= 4'(MAX_FAIL));

    // A fresh valid press shifts only when no close/enter decision consumes the cycle.
    assign w_key_shift   = r_ke1 && !r_ke2 && r_kv
                         && ((r_state == ST_OPEN) || (r_state == ST_LOCKED))
                         && !w_close_act && !w_enter_act;
    assign w_secret_load = w_close_act;
    assign w_key_clear   = w_close_act || (w_enter_act && !w_full) || (r_state == ST_CHECK);

    assign bus.key_shift   = w_key_shift;
    assign bus.key_code    = r_key_code;
    assign bus.key_clear   = w_key_clear;
    assign bus.secret_load = w_secret_load;
    assign bus.lock        = r_lock;
    assign bus.alarm       = r_alarm;
    assign bus.fail_cnt    = r_fail_cnt;
    assign bus.digits      = r_digits;

    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_OPEN;
            r_ke1      <= 1'b0;
            r_ke2      <= 1'b0;
            r_kv       <= 1'b0;
            r_key_code <= 4'h0;
            r_lock     <= 1'b0;
            r_alarm    <= 1'b0;
            r_fail_cnt <= '0;
            r_digits   <= '0;
            r_timer    <= '0;
        end else begin
            r_ke1 <= |bus.tenkey;
            r_ke2 <= r_ke1;
            r_kv  <= w_onehot;
            if (w_onehot) r_key_code <= enc(bus.tenkey);

            if (w_key_clear) begin
                r_digits <= '0;
            end else if (w_key_shift && !w_full) begin
                r_digits <= r_digits + CNT_W'(1);
            end

            case (r_state)
                ST_OPEN: begin
                    if (w_close_act) begin
                        r_lock  <= 1'b1;
                        r_state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_enter_act && w_full) r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (bus.match) begin
                        r_lock     <= 1'b0;
                        r_fail_cnt <= '0;
                        r_state    <= ST_OPEN;
                    end else if (w_fail_limit) begin
                        r_fail_cnt <= CNT_W'(MAX_FAIL);
                        r_alarm    <= 1'b1;
                        r_timer    <= TIMER_W'(LOCKOUT_CYC - 1);
                        r_state    <= ST_LOCKOUT;
                    end else begin
                        r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                        r_state    <= ST_LOCKED;
                    end
                end
                ST_LOCKOUT: begin
                    // Alarm spans timer values LOCKOUT_CYC-1 down to 0 inclusive.
                    if (r_timer == '0) begin
                        r_alarm    <= 1'b0;
                        r_fail_cnt <= '0;
                        r_state    <= ST_LOCKED;
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end
                default: r_state <= ST_OPEN;
            endcase
        end
    end
endmodule
